// File: rtl/pb_event_if.sv
// Event handshake bundle between the push-button arbiter (master) and its consumer (slave).
interface pb_event_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_btn;
  logic       ev_rep;

  modport master (output ev_valid, output ev_btn, output ev_rep, input ev_ready);
  modport slave  (input ev_valid, input ev_btn, input ev_rep, output ev_ready);
endinterface

// File: rtl/pb_event_arbiter.sv
// Turns debounced button presses (and optional auto-repeat ticks, macro PB_AUTO_REPEAT_EN)
// into a single round-robin arbitrated valid/ready event stream with a saturating drop counter.
module pb_event_arbiter #(
  parameter int N_BTN        = 4,
  parameter int REPEAT_DELAY = 400,
  parameter int REPEAT_RATE  = 100
) (
  input  logic             clk_1ms,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn,
  pb_event_if.master       ev,
  output logic [7:0]       drop_cnt
);

  typedef enum logic {S_IDLE, S_OFFER} state_t;

  if (N_BTN != 4 || REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY || REPEAT_DELAY > 1023)
  begin : g_cfg_check
    $error("pb_event_arbiter: unsupported N_BTN/REPEAT_DELAY/REPEAT_RATE combination");
  end

  state_t           r_state;
  logic             r_ev_valid;
  logic [1:0]       r_ev_btn;
  logic             r_ev_rep;
  logic [7:0]       r_drop;
  logic [N_BTN-1:0] r_pending;
  logic [N_BTN-1:0] r_rep;
  logic [N_BTN-1:0] r_btn_q;
  logic [1:0]       r_ptr;

  logic [N_BTN-1:0] w_press;
  logic [N_BTN-1:0] w_tick;
  logic [N_BTN-1:0] w_set;
  logic [N_BTN-1:0] w_clr;
  logic [1:0]       w_gnt_idx;
  logic             w_do_grant;
  logic [2:0]       w_drops;

  // Search starts one past the last grant and wraps; the last hit in the
  // descending loop is the nearest requester after ptr.
  function automatic logic [1:0] f_rr_pick(input logic [N_BTN-1:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    f_rr_pick = ptr;
    for (int k = N_BTN; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) f_rr_pick = idx;
    end
  endfunction

  function automatic logic [2:0] f_popcnt(input logic [N_BTN-1:0] v);
    f_popcnt = '0;
    for (int i = 0; i < N_BTN; i++) f_popcnt = f_popcnt + 3'(v[i]);
  endfunction

  function automatic logic [7:0] f_sat_add(input logic [7:0] cnt, input logic [2:0] inc);
    logic [8:0] sum;
    sum = {1'b0, cnt} + 9'(inc);
    f_sat_add = sum[8] ? 8'hFF : sum[7:0];
  endfunction

`ifdef PB_AUTO_REPEAT_EN
  localparam logic [9:0] LP_TICK_AT = 10'(REPEAT_DELAY - 1);
  localparam logic [9:0] LP_RELOAD  = 10'(REPEAT_DELAY - REPEAT_RATE);

  logic [9:0] r_hold [N_BTN];

  always_comb begin
    w_tick = '0;
    for (int i = 0; i < N_BTN; i++)
      w_tick[i] = btn[i] & r_btn_q[i] & (r_hold[i] == LP_TICK_AT);
  end

  // Counter value equals cycles held since the press edge; reload keeps the
  // next tick REPEAT_RATE cycles away without ever wrapping.
  always_ff @(posedge clk_1ms) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BTN; i++) r_hold[i] <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (!btn[i] || w_press[i]) r_hold[i] <= '0;
        else if (w_tick[i])        r_hold[i] <= LP_RELOAD;
        else                       r_hold[i] <= r_hold[i] + 10'd1;
      end
    end
  end
`else
  assign w_tick = '0;
`endif

  always_comb begin
    w_press    = btn & ~r_btn_q;
    w_set      = w_press | w_tick;
    w_gnt_idx  = f_rr_pick(r_pending, r_ptr);
    w_do_grant = (|r_pending) && ((r_state == S_IDLE) || ev.ev_ready);
    w_clr      = '0;
    if (w_do_grant) w_clr[w_gnt_idx] = 1'b1;
    w_drops    = f_popcnt(w_set & r_pending);
  end

  // A same-edge set wins over the grant clear; the granted event carries the
  // rep flag as it stood before any same-edge overwrite.
  always_ff @(posedge clk_1ms) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ev_valid <= 1'b0;
      r_ev_btn   <= '0;
      r_ev_rep   <= 1'b0;
      r_drop     <= '0;
      r_pending  <= '0;
      r_rep      <= '0;
      r_btn_q    <= '0;
      r_ptr      <= 2'(N_BTN - 1);
    end else begin
      r_btn_q   <= btn;
      r_pending <= (r_pending & ~w_clr) | w_set;
      r_rep     <= (r_rep & ~w_set) | w_tick;
      r_drop    <= f_sat_add(r_drop, w_drops);
      if (w_do_grant) begin
        r_ev_btn <= w_gnt_idx;
        r_ev_rep <= r_rep[w_gnt_idx];
        r_ptr    <= w_gnt_idx;
      end
      case (r_state)
        S_IDLE: begin
          if (w_do_grant) begin
            r_ev_valid <= 1'b1;
            r_state    <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (ev.ev_ready && !w_do_grant) begin
            r_ev_valid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ev.ev_valid = r_ev_valid;
  assign ev.ev_btn   = r_ev_btn;
  assign ev.ev_rep   = r_ev_rep;
  assign drop_cnt    = r_drop;

endmodule

// File: tb/tb_pb_event_arbiter.sv
// Directed and randomized checks of pb_event_arbiter against an event-level reference model.
module tb_pb_event_arbiter;
  localparam int D = 400;
  localparam int R = 100;
`ifdef PB_AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic [7:0] drop_cnt;

  pb_event_if ev ();

  pb_event_arbiter #(.N_BTN(4), .REPEAT_DELAY(D), .REPEAT_RATE(R)) dut (
    .clk_1ms (clk),
    .rst_n   (rst_n),
    .btn     (btn),
    .ev      (ev),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: valid doubles as "an event is being offered".
  int m_pend [4];
  int m_rep  [4];
  int m_btnq [4];
  int m_age  [4];
  int m_valid, m_btn, m_evrep, m_ptr, m_drop;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = 0; m_rep[i] = 0; m_btnq[i] = 0; m_age[i] = 0;
    end
    m_valid = 0; m_btn = 0; m_evrep = 0; m_ptr = 3; m_drop = 0;
  endfunction

  function automatic void model_edge();
    int pre [4];
    int press [4];
    int tick [4];
    int found;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 4; i++) begin
      pre[i]   = m_pend[i];
      press[i] = (btn[i] && !m_btnq[i]) ? 1 : 0;
      tick[i]  = 0;
      if (REP_EN && btn[i] && m_btnq[i] && (m_age[i] + 1 >= D) && (((m_age[i] + 1 - D) % R) == 0))
        tick[i] = 1;
    end
    if (!m_valid || ev.ev_ready) begin
      found = -1;
      for (int k = 1; k <= 4; k++)
        if (found < 0 && pre[(m_ptr + k) % 4] != 0) found = (m_ptr + k) % 4;
      if (found >= 0) begin
        m_valid = 1; m_btn = found; m_evrep = m_rep[found];
        m_pend[found] = 0; m_ptr = found;
      end else begin
        m_valid = 0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (press[i] || tick[i]) begin
        if (pre[i] && m_drop < 255) m_drop++;
        m_pend[i] = 1;
        m_rep[i]  = tick[i];
      end
      if (!btn[i] || press[i]) m_age[i] = 0;
      else                     m_age[i] = m_age[i] + 1;
      m_btnq[i] = btn[i];
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_valid", 32'(ev.ev_valid), 32'(m_valid));
    if (m_valid != 0) begin
      chk("model_btn", 32'(ev.ev_btn), 32'(m_btn));
      chk("model_rep", 32'(ev.ev_rep), 32'(m_evrep));
    end
    chk("model_drop", 32'(drop_cnt), 32'(m_drop));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  int n_ev;
  int ev_t [8];
  int ev_r [8];
  int exp_t [4];

  initial begin
    model_reset();
    ev.ev_ready = 1'b1;

    // Reset state
    rst_n = 1'b0;
    btn   = 4'b0000;
    step();
    step();
    chk("rst_valid", 32'(ev.ev_valid), 0);
    chk("rst_btn",   32'(ev.ev_btn),   0);
    chk("rst_rep",   32'(ev.ev_rep),   0);
    chk("rst_drop",  32'(drop_cnt),    0);
    rst_n = 1'b1;

    // Single press of button 2: event visible two edges after the press edge
    btn = 4'b0100;
    step();
    chk("p2_lat0", 32'(ev.ev_valid), 0);
    step();
    chk("p2_valid", 32'(ev.ev_valid), 1);
    chk("p2_btn",   32'(ev.ev_btn),   2);
    chk("p2_rep",   32'(ev.ev_rep),   0);
    n_ev = 1;
    step();
    chk("p2_onecyc", 32'(ev.ev_valid), 0);
    btn = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      step();
      if (ev.ev_valid) n_ev++;
    end
    chk("p2_count", 32'(n_ev), 1);

    // Simultaneous presses of 0 and 3 served back to back
    do_reset();
    btn = 4'b1001;
    step();
    step();
    chk("bb_first_v", 32'(ev.ev_valid), 1);
    chk("bb_first",   32'(ev.ev_btn),   0);
    step();
    chk("bb_second_v", 32'(ev.ev_valid), 1);
    chk("bb_second",   32'(ev.ev_btn),   3);
    step();
    chk("bb_idle", 32'(ev.ev_valid), 0);
    chk("bb_drop", 32'(drop_cnt),    0);
    btn = 4'b0000;
    step();

    // Stalled consumer: offered event holds, a press onto a pending bit is dropped
    do_reset();
    ev.ev_ready = 1'b0;
    btn = 4'b0010; step();
    btn = 4'b0000; step();
    chk("st_valid", 32'(ev.ev_valid), 1);
    chk("st_btn",   32'(ev.ev_btn),   1);
    btn = 4'b0010; step();
    btn = 4'b0000; step();
    btn = 4'b0010; step();
    btn = 4'b0000; step();
    chk("st_hold_v", 32'(ev.ev_valid), 1);
    chk("st_hold_b", 32'(ev.ev_btn),   1);
    chk("st_drop",   32'(drop_cnt),    1);
    ev.ev_ready = 1'b1;
    step();
    chk("st_next_v", 32'(ev.ev_valid), 1);
    chk("st_next_b", 32'(ev.ev_btn),   1);
    step();
    chk("st_done", 32'(ev.ev_valid), 0);
    chk("st_drop2", 32'(drop_cnt),   1);

    // Long hold of button 1
    do_reset();
    ev.ev_ready = 1'b1;
    n_ev = 0;
    for (int c = 0; c < 660; c++) begin
      btn = (c < 650) ? 4'b0010 : 4'b0000;
      step();
      if (ev.ev_valid && n_ev < 8) begin
        ev_t[n_ev] = c;
        ev_r[n_ev] = int'(ev.ev_rep);
        n_ev++;
      end
    end
    exp_t[0] = 1; exp_t[1] = 1 + D; exp_t[2] = 1 + D + R; exp_t[3] = 1 + D + 2 * R;
    chk("hold_count", 32'(n_ev), REP_EN ? 4 : 1);
    for (int k = 0; k < 4; k++) begin
      if (k < n_ev && (k == 0 || REP_EN)) begin
        chk("hold_time", 32'(ev_t[k]), 32'(exp_t[k]));
        chk("hold_rep",  32'(ev_r[k]), (k == 0) ? 0 : 1);
      end
    end

    // Reset while offering, with button 0 held through it
    do_reset();
    ev.ev_ready = 1'b0;
    btn = 4'b0001;
    step();
    step();
    chk("ro_offer", 32'(ev.ev_valid), 1);
    rst_n = 1'b0;
    step();
    chk("ro_cleared", 32'(ev.ev_valid), 0);
    rst_n = 1'b1;
    step();
    chk("ro_press_edge", 32'(ev.ev_valid), 0);
    step();
    chk("ro_fresh_v", 32'(ev.ev_valid), 1);
    chk("ro_fresh_b", 32'(ev.ev_btn),   0);
    chk("ro_fresh_r", 32'(ev.ev_rep),   0);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 7) == 0) btn[i] = ~btn[i];
      ev.ev_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
